node_input_arbiter: RTL and testbench
=====================================

Name: node_input_arbiter

Overview:
- Upstream feeder for a processing node.
- Collects 4-bit nibbles from four neighbour channels, each with a valid/ready handshake.
- Picks one channel per cycle using round-robin arbitration.
- Stores the accepted nibble and its source index in a small FIFO, then presents them to the node on a single valid/ready port.
- Decouples neighbouring nodes so the node never stalls a channel that has no grant.

Parameters:
- WIDTH, 4: data bits per channel.
- DEPTH, 2: FIFO entries. Must be a power of two, ≥2.

Ports:
- clk, input, 1: single clock. All state updates on the rising edge.
- rst, input, 1: synchronous reset, active-high.
- in_data, input, 4*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid, input, 4: per-channel valid.
- in_ready, output, 4: per-channel ready, combinational.
- out_data, output, WIDTH: FIFO head data.
- out_src, output, 2: channel index of the FIFO head.
- out_valid, output, 1: FIFO not empty.
- out_ready, input, 1: downstream node accepts the head.
- fifo_count, output, clog2(DEPTH)+1: current occupancy.

Behaviour:
- Reset:
  - FIFO emptied: fifo_count=0, out_valid=0.
  - out_data=0, out_src=0, read/write pointers = 0.
  - Round-robin pointer last_grant=3, so channel 0 has first priority.
  - Reset dominates any handshake in the same cycle.
  - Mid-operation reset drops all queued entries.
- Grant (combinational):
  - Scan in_valid starting at (last_grant+1) mod 4, wrapping.
  - The first valid channel found is the grant; none found means no grant.
- in_ready[i] = (grant==i) AND (fifo_count<DEPTH) AND NOT rst.
  - At most one in_ready bit is high.
  - in_ready is independent of out_ready: no pass-through when the FIFO is full.
- Push:
  - Occurs when in_valid[g] AND in_ready[g].
  - At the edge, {g, in_data[g]} is written at the write pointer, the write pointer increments mod DEPTH, and last_grant←g.
  - last_grant is updated only on a push.
- Pop:
  - Occurs when out_valid AND out_ready.
  - The read pointer increments mod DEPTH.
  - out_data/out_src always show the entry at the read pointer. They are 0 when empty (outputs masked).
- Simultaneous push and pop: both occur and fifo_count is unchanged. Allowed at any occupancy below DEPTH.
- Full (count=DEPTH): all in_ready=0; a pop in that cycle leaves count=DEPTH-1.
- Empty: out_ready is ignored; count never underflows.
- Latency: a nibble accepted at edge N appears on out_* after edge N (visible in cycle N+1) if the FIFO was empty. Minimum latency is 1 cycle.
- Throughput: 1 nibble per cycle sustained when out_ready=1.
- Upstream rule: a channel holds in_data stable while in_valid=1 and in_ready=0. in_valid must not drop before acceptance; the arbiter does not check this.
- No data loss: every accepted nibble is output exactly once, in acceptance order.
- Fairness: with all four valid continuously and out_ready=1, the grant sequence is 0,1,2,3,0,…

Test Plan:
- Reset then idle: rst=1 for 2 cycles, all inputs 0 → in_ready=0000, out_valid=0, fifo_count=0, out_data=0.
- Single channel, no stall: in_valid=0100, in_data[2]=0xA, out_ready=1 → in_ready=0100. Next cycle out_valid=1, out_data=0xA, out_src=2, count=1, then 0 after the pop.
- Round-robin fairness: in_valid=1111 held, data ch i = i+5, out_ready=1 → out_src sequence 0,1,2,3,0,1 and out_data 5,6,7,8,5,6, one per cycle after 1-cycle latency.
- Full/backpressure: out_ready=0, in_valid=0011, data 0x3/0x9 → grants ch0 then ch1, count=2, in_ready=0000 thereafter. Raise out_ready for 1 cycle: pops {0,0x3}, count=1, ch0 granted again next cycle.
- Simultaneous push/pop at count=1: out_ready=1, in_valid=1000, data 0xF → count stays 1. Head changes to the previously queued entry, then {3,0xF}.
- Reset mid-operation: count=2 with two entries, assert rst for 1 cycle while in_valid=1111 → no push occurs, count=0, out_valid=0. First grant after reset goes to channel 0.

Source files
------------

// File: rtl/node_input_arbiter.sv
// Round-robin collector of nibbles from four neighbour channels into a small FIFO feeding one node port.
// Latency: a nibble accepted at edge N is visible on out_* in cycle N+1 when the FIFO was empty.
// Backpressure: in_ready depends only on grant and FIFO occupancy; a full FIFO stalls every channel regardless of out_ready.

// Generic synchronous FIFO with registered pointers and count; read data masked to zero when empty.
module nia_fifo #(
  parameter int W     = 6,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_vld,
  input  logic [W-1:0]             wr_dat,
  output logic                     full,
  output logic                     rd_vld,
  input  logic                     rd_rdy,
  output logic [W-1:0]             rd_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push;
  logic          pop;

  assign full   = (count_q == CW'(DEPTH));
  assign rd_vld = (count_q != '0);
  assign push   = wr_vld && !full;
  assign pop    = rd_vld && rd_rdy;
  assign count  = count_q;
  // Head entry is exposed only while something is queued, so an empty FIFO shows zeros.
  assign rd_dat = rd_vld ? mem_q[rd_ptr_q] : '0;

  // Next-state for storage, pointers and occupancy; push and pop may coincide.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset empties the FIFO and wins over any same-cycle handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// Top: round-robin grant over four channels, accepted nibble tagged with its source index.
module node_input_arbiter #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [4*WIDTH-1:0]       in_data,
  input  logic [3:0]               in_valid,
  output logic [3:0]               in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [1:0]               out_src,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  logic [1:0]       last_grant_q, last_grant_d;
  logic [1:0]       grant;
  logic             grant_vld;
  logic [1:0]       scan_idx;
  logic             fifo_full;
  logic             push;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH+1:0] wr_dat;
  logic [WIDTH+1:0] rd_dat;

  // Round-robin scan starting just after the last granted channel, wrapping mod 4.
  always_comb begin
    grant_vld = 1'b0;
    grant     = 2'd0;
    scan_idx  = 2'd0;
    for (int k = 0; k < 4; k++) begin
      scan_idx = last_grant_q + 2'(k + 1);
      if (!grant_vld && in_valid[scan_idx]) begin
        grant_vld = 1'b1;
        grant     = scan_idx;
      end
    end
  end

  // One-hot ready to the granted channel only, and only while the FIFO has room.
  always_comb begin
    in_ready = 4'b0000;
    if (grant_vld && !fifo_full && !rst) begin
      in_ready[grant] = 1'b1;
    end
  end

  assign push     = |(in_valid & in_ready);
  assign sel_data = in_data[int'(grant)*WIDTH +: WIDTH];
  assign wr_dat   = {grant, sel_data};

  // Priority pointer advances only when a nibble is actually accepted.
  always_comb begin
    last_grant_d = last_grant_q;
    if (push) begin
      last_grant_d = grant;
    end
  end

  // Reset points last_grant at channel 3 so channel 0 is first in line.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 2'd3;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  nia_fifo #(
    .W     (WIDTH + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (push),
    .wr_dat (wr_dat),
    .full   (fifo_full),
    .rd_vld (out_valid),
    .rd_rdy (out_ready),
    .rd_dat (rd_dat),
    .count  (fifo_count)
  );

  assign out_src  = rd_dat[WIDTH+1:WIDTH];
  assign out_data = rd_dat[WIDTH-1:0];
endmodule

// File: tb/tb_node_input_arbiter.sv
// Directed bench for node_input_arbiter: stimulus thread queues expected {src,data} per accepted nibble,
// a negedge monitor pops and compares on every output handshake.
// Status outputs (in_ready, fifo_count, head) are checked against hand-computed values at negedge.
module tb_node_input_arbiter;
  logic        clk;
  logic        rst;
  logic [15:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [3:0]  out_data;
  logic [1:0]  out_src;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  fifo_count;

  int total = 0;
  int bad   = 0;
  logic [5:0] exp_q[$];
  logic [5:0] exp_e;

  node_input_arbiter #(.WIDTH(4), .DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  // Apply one cycle of inputs just after the rising edge, then wait to the falling edge for checks.
  task automatic drive(input logic r, input logic [3:0] v, input logic [15:0] d, input logic ordy);
    @(posedge clk);
    #1;
    rst       = r;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    @(negedge clk);
  endtask

  // Monitor: every output handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected: got src=%0d data=%0h want no output", out_src, out_data);
      end else begin
        exp_e = exp_q.pop_front();
        if ({out_src, out_data} !== exp_e) begin
          bad++;
          $display("FAIL pop_data: got src=%0d data=%0h want src=%0d data=%0h",
                   out_src, out_data, exp_e[5:4], exp_e[3:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 4'b0000;
    in_data   = 16'h0000;
    out_ready = 1'b0;

    // Reset then idle
    @(negedge clk);
    drive(1'b1, 4'b0000, 16'h0000, 1'b0);
    chk("rst_in_ready",  int'(in_ready),   0);
    chk("rst_out_valid", int'(out_valid),  0);
    chk("rst_count",     int'(fifo_count), 0);
    chk("rst_out_data",  int'(out_data),   0);
    chk("rst_out_src",   int'(out_src),    0);

    // Single channel, no stall
    drive(1'b0, 4'b0100, 16'h0A00, 1'b1);
    exp_q.push_back({2'd2, 4'hA});
    chk("single_in_ready", int'(in_ready),   4'b0100);
    chk("single_count0",   int'(fifo_count), 0);
    drive(1'b0, 4'b0000, 16'h0000, 1'b1);
    chk("single_out_valid", int'(out_valid),  1);
    chk("single_out_data",  int'(out_data),   4'hA);
    chk("single_out_src",   int'(out_src),    2);
    chk("single_count1",    int'(fifo_count), 1);
    drive(1'b0, 4'b0000, 16'h0000, 1'b1);
    chk("single_drained",   int'(fifo_count), 0);
    chk("single_empty_vld", int'(out_valid),  0);
    chk("single_empty_dat", int'(out_data),   0);

    // Round-robin fairness from a fresh reset
    drive(1'b1, 4'b0000, 16'h0000, 1'b0);
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 4'b1111, 16'h8765, 1'b1);
      exp_q.push_back({2'(k % 4), 4'(5 + k % 4)});
      chk($sformatf("rr_in_ready_%0d", k), int'(in_ready), 1 << (k % 4));
      if (k > 0) chk($sformatf("rr_count_%0d", k), int'(fifo_count), 1);
    end
    drive(1'b0, 4'b0000, 16'h8765, 1'b1);
    chk("rr_tail_count", int'(fifo_count), 1);
    drive(1'b0, 4'b0000, 16'h0000, 1'b1);
    chk("rr_drained", int'(fifo_count), 0);

    // Full / backpressure: last grant was ch1, so ch0 wins first
    drive(1'b0, 4'b0011, 16'h0093, 1'b0);
    exp_q.push_back({2'd0, 4'h3});
    chk("full_grant0", int'(in_ready), 4'b0001);
    drive(1'b0, 4'b0011, 16'h0093, 1'b0);
    exp_q.push_back({2'd1, 4'h9});
    chk("full_grant1", int'(in_ready),   4'b0010);
    chk("full_count1", int'(fifo_count), 1);
    drive(1'b0, 4'b0011, 16'h0093, 1'b0);
    chk("full_in_ready", int'(in_ready),   4'b0000);
    chk("full_count2",   int'(fifo_count), 2);
    chk("full_head_dat", int'(out_data),   4'h3);
    chk("full_head_src", int'(out_src),    0);
    drive(1'b0, 4'b0011, 16'h0093, 1'b1);
    chk("full_pop_no_ready", int'(in_ready), 4'b0000);
    drive(1'b0, 4'b0011, 16'h0093, 1'b1);
    exp_q.push_back({2'd0, 4'h3});
    chk("after_pop_count", int'(fifo_count), 1);
    chk("after_pop_grant", int'(in_ready),   4'b0001);
    chk("after_pop_src",   int'(out_src),    1);

    // Simultaneous push/pop at count=1
    drive(1'b0, 4'b1000, 16'hF093, 1'b1);
    exp_q.push_back({2'd3, 4'hF});
    chk("pp_count",    int'(fifo_count), 1);
    chk("pp_in_ready", int'(in_ready),   4'b1000);
    chk("pp_head_dat", int'(out_data),   4'h3);
    chk("pp_head_src", int'(out_src),    0);
    drive(1'b0, 4'b0000, 16'hF093, 1'b1);
    chk("pp_count2",    int'(fifo_count), 1);
    chk("pp_head2_src", int'(out_src),    3);
    chk("pp_head2_dat", int'(out_data),   4'hF);
    drive(1'b0, 4'b0000, 16'h0000, 1'b0);
    chk("pp_drained", int'(fifo_count), 0);

    // Reset mid-operation drops two queued entries
    drive(1'b0, 4'b0011, 16'h0093, 1'b0);
    chk("mr_fill0", int'(in_ready), 4'b0001);
    drive(1'b0, 4'b0011, 16'h0093, 1'b0);
    chk("mr_fill1", int'(in_ready), 4'b0010);
    drive(1'b1, 4'b1111, 16'h8765, 1'b0);
    chk("mr_count_full", int'(fifo_count), 2);
    chk("mr_rst_ready",  int'(in_ready),   4'b0000);
    drive(1'b0, 4'b1111, 16'h8765, 1'b1);
    exp_q.push_back({2'd0, 4'h5});
    chk("mr_count0",    int'(fifo_count), 0);
    chk("mr_out_valid", int'(out_valid),  0);
    chk("mr_out_data",  int'(out_data),   0);
    chk("mr_grant0",    int'(in_ready),   4'b0001);
    drive(1'b0, 4'b0000, 16'h0000, 1'b1);
    chk("mr_head_src", int'(out_src),    0);
    chk("mr_head_dat", int'(out_data),   4'h5);
    chk("mr_count1",   int'(fifo_count), 1);
    drive(1'b0, 4'b0000, 16'h0000, 1'b0);
    chk("mr_final_count", int'(fifo_count), 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
